// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage sequencing controller for the HI/LO mult/div unit.
// Optional divide-by-zero guard: define MD_DIVZERO_GUARD_EN.
//
// Ports:
//   Clk, Rst        clock (rising edge), synchronous active-high reset
//   Req, Func       valid MD instruction in E and its function code
//   RsVal, RtVal    forwarded operands, passed straight to the unit
//   Flush           exception/interrupt kill of the E-stage instruction
//   MdBusy          busy from the MD unit
//   MdStart/MdOp/MdWe/MdHiLo/MdD1/MdD2  unit control and data
//   HiLoSel         MFHI/MFLO read-mux select (1 = HI)
//   Stall           freeze F/D/E while HI/LO is unavailable
//   DivZero         one-cycle divide-by-zero flag (guard builds only)
module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic [2:0]  Func,
    input  logic [31:0] RsVal,
    input  logic [31:0] RtVal,
    input  logic        Flush,
    input  logic        MdBusy,
    output logic        MdStart,
    output logic [1:0]  MdOp,
    output logic        MdWe,
    output logic        MdHiLo,
    output logic [31:0] MdD1,
    output logic [31:0] MdD2,
    output logic        HiLoSel,
    output logic        Stall
`ifdef MD_DIVZERO_GUARD_EN
   ,output logic        DivZero
`endif
);

    localparam int MAXL = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          act;

    // MdBusy keeps MD instructions held after a reset mid-operation,
    // when the controller is IDLE but the unit is still counting.
    assign Stall = Req & ~Flush & ((state_q == RUN) | MdBusy);
    assign act   = Req & ~Flush & ~Stall;

`ifdef MD_DIVZERO_GUARD_EN
    logic dz;
    logic dz_q;

    assign dz      = act & ~Func[2] & Func[1] & (RtVal == 32'd0);
    assign MdStart = act & ~Func[2] & ~dz;
    assign DivZero = dz_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz;
        end
    end
`else
    assign MdStart = act & ~Func[2];
`endif

    assign MdOp    = Func[1:0];
    assign MdWe    = act & Func[2] & ~Func[1];
    assign MdHiLo  = Func[0];
    assign HiLoSel = Func[0];
    assign MdD1    = RsVal;
    assign MdD2    = RtVal;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (MdStart) begin
                    state_d = RUN;
                    cnt_d   = Func[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
                end
            end
            RUN: begin
                // The last counted edge is the one at which HI/LO updates.
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: scoreboard bench for md_issue_ctrl with a
// behavioural HI/LO multiply/divide unit attached.
module tb_md_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        Clk = 1'b0;
    logic        Rst, Req, Flush;
    logic        MdBusy;
    logic [2:0]  Func;
    logic [31:0] RsVal, RtVal;
    logic        MdStart, MdWe, MdHiLo, HiLoSel, Stall;
    logic [1:0]  MdOp;
    logic [31:0] MdD1, MdD2;
`ifdef MD_DIVZERO_GUARD_EN
    logic        DivZero;
`endif

    always #5 Clk = ~Clk;

    md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Func(Func),
        .RsVal(RsVal), .RtVal(RtVal), .Flush(Flush), .MdBusy(MdBusy),
        .MdStart(MdStart), .MdOp(MdOp), .MdWe(MdWe), .MdHiLo(MdHiLo),
        .MdD1(MdD1), .MdD2(MdD2), .HiLoSel(HiLoSel), .Stall(Stall)
`ifdef MD_DIVZERO_GUARD_EN
       ,.DivZero(DivZero)
`endif
    );

    // behavioural MD unit: fixed latency, ignores Rst, drops We while busy
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0, u_hi = 32'd0, u_lo = 32'd0;
    logic        u_busy = 1'b0;
    int          u_cnt = 0;

    assign MdBusy = u_busy;

    function automatic logic [63:0] md_calc(logic [1:0] op,
                                            logic [31:0] a, logic [31:0] b);
        logic [63:0] r;
        case (op)
            2'b00: r = {32'd0, a} * {32'd0, b};
            2'b01: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'b10: r = (b == 0) ? 64'd0 : {a % b, a / b};
            default: r = (b == 0) ? 64'd0 :
                {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        endcase
        return r;
    endfunction

    always @(posedge Clk) begin
        if (u_busy) begin
            if (u_cnt == 1) begin
                u_busy <= 1'b0;
                hi_m   <= u_hi;
                lo_m   <= u_lo;
            end
            u_cnt <= u_cnt - 1;
        end else if (MdStart) begin
            u_busy       <= 1'b1;
            u_cnt        <= MdOp[1] ? DIV_LAT : MULT_LAT;
            {u_hi, u_lo} <= md_calc(MdOp, MdD1, MdD2);
        end else if (MdWe) begin
            if (MdHiLo) hi_m <= MdD1;
            else        lo_m <= MdD1;
        end
    end

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic        last_start, last_we, act_in_stall;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Hold one instruction in E until it is no longer stalled.
    task automatic issue(input logic [2:0] f, input logic [31:0] rs,
                         input logic [31:0] rt, output int stalls);
        logic [31:0] rd;
        Req = 1'b1; Flush = 1'b0; Func = f; RsVal = rs; RtVal = rt;
        stalls = 0;
        act_in_stall = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Stall) break;
            if (MdWe || MdStart) act_in_stall = 1'b1;
            stalls++;
            if (stalls >= 64) break;
            @(posedge Clk); #1;
        end
        if (stalls >= 64) chk("stall_timeout", stalls, 0);
        last_start = MdStart;
        last_we    = MdWe;
        if (f[2:1] == 2'b11) begin
            rd = HiLoSel ? hi_m : lo_m;
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else chk(f[0] ? "mfhi" : "mflo", rd, exp_q.pop_front());
        end
        @(posedge Clk); #1;
        Req = 1'b0;
    endtask

    task automatic mf(input logic [2:0] f, input logic [31:0] exp,
                      input int exp_stalls, input string tag);
        int s;
        exp_q.push_back(exp);
        issue(f, 32'd0, 32'd0, s);
        chk(tag, s, exp_stalls);
    endtask

    task automatic idle(input int n);
        Req = 1'b0; Flush = 1'b0;
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    int s;

    initial begin
        Rst = 1'b1; Req = 1'b0; Flush = 1'b0; Func = 3'd0;
        RsVal = 32'd0; RtVal = 32'd0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("rst_start", MdStart, 0);
        chk("rst_we", MdWe, 0);
        chk("rst_stall", Stall, 0);
`ifdef MD_DIVZERO_GUARD_EN
        chk("rst_divzero", DivZero, 0);
`endif
        @(posedge Clk); #1;

        // MULT -1 * 2 then MFHI/MFLO
        issue(3'b001, 32'hFFFF_FFFF, 32'd2, s);
        chk("mult_start", last_start, 1);
        chk("mult_nostall", s, 0);
        mf(3'b111, 32'hFFFF_FFFF, MULT_LAT, "mfhi_stalls");
        mf(3'b110, 32'hFFFF_FFFE, 0, "mflo_stalls");

        // DIVU 100/7 then MFLO immediately, then MFHI
        issue(3'b010, 32'd100, 32'd7, s);
        chk("divu_start", last_start, 1);
        mf(3'b110, 32'd14, DIV_LAT, "divu_mflo_stalls");
        mf(3'b111, 32'd2, 0, "divu_mfhi_stalls");

        // MTHI in IDLE: single-cycle write, no stall
        issue(3'b101, 32'h0000_ABCD, 32'd0, s);
        chk("mthi_we", last_we, 1);
        chk("mthi_nostall", s, 0);
        mf(3'b111, 32'h0000_ABCD, 0, "mthi_rd_stalls");

        // MULT 3*4 then MTLO during RUN
        issue(3'b001, 32'd3, 32'd4, s);
        issue(3'b100, 32'h0000_1234, 32'd0, s);
        chk("mtlo_stalls", s, MULT_LAT);
        chk("mtlo_we_in_run", act_in_stall, 0);
        chk("mtlo_we_release", last_we, 1);
        mf(3'b110, 32'h0000_1234, 0, "mtlo_rd_stalls");
        mf(3'b111, 32'd0, 0, "mult_hi_stalls");

        // Flush on a DIV in IDLE
        Req = 1'b1; Flush = 1'b1; Func = 3'b011;
        RsVal = 32'd50; RtVal = 32'd3;
        @(negedge Clk);
        chk("flush_start", MdStart, 0);
        chk("flush_stall", Stall, 0);
        @(posedge Clk); #1;
        idle(1);
        mf(3'b110, 32'h0000_1234, 0, "flush_mflo_stalls");

        // Flush forces Stall low even while RUN
        issue(3'b000, 32'd6, 32'd7, s);
        Req = 1'b1; Flush = 1'b1; Func = 3'b111;
        @(negedge Clk);
        chk("flush_run_stall", Stall, 0);
        chk("flush_run_we", MdWe, 0);
        @(posedge Clk); #1;
        idle(MULT_LAT);
        mf(3'b110, 32'd42, 0, "multu_lo_stalls");

`ifdef MD_DIVZERO_GUARD_EN
        issue(3'b011, 32'd5, 32'd0, s);
        chk("dz_start", last_start, 0);
        chk("dz_nostall", s, 0);
        @(negedge Clk);
        chk("dz_pulse", DivZero, 1);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("dz_clear", DivZero, 0);
        @(posedge Clk); #1;
        mf(3'b110, 32'd42, 0, "dz_lo_stalls");
        mf(3'b111, 32'd0, 0, "dz_hi_stalls");
`endif

        // DIV -20/3, Rst pulsed two cycles after the Start
        issue(3'b011, 32'hFFFF_FFEC, 32'd3, s);
        chk("div_start", last_start, 1);
        idle(1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        mf(3'b111, 32'hFFFF_FFFE, DIV_LAT - 2, "rst_mfhi_stalls");
        mf(3'b110, 32'hFFFF_FFFA, 0, "rst_mflo_stalls");

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
